// File: rtl/graphite_pkg.sv
// graphite_pkg: shared types and widths for the graphite VRAM path.
//   arb_state_t  - arbiter FSM state encoding.
//   VRAM_*_W     - default VRAM address/data/mask widths (ARGB4444 words).
//   idx_width()  - width of an index into n items, never less than 1 bit.
package graphite_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_GAP
  } arb_state_t;

  localparam int VRAM_ADDR_W = 16;
  localparam int VRAM_DATA_W = 16;
  localparam int VRAM_MASK_W = 4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector.
// Ports:
//   req      in  N    request vector.
//   last     in  IW   index granted most recently; search starts just above it.
//   grant    out IW   first requesting index at last+1, last+2, ... (mod N).
//   any_req  out 1    at least one request is high.
// grant is only meaningful while any_req is high.
module rr_picker
  import graphite_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] grant,
  output logic          any_req
);

  logic [IW-1:0] idx;
  logic          found;

  // Offsets run 1..N so that last itself is tried only after every other
  // requester; a lone requester therefore still wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last) + k) % N);
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one VRAM port between NUM_REQ requesters
// (index 0 = rasterizer) with round-robin arbitration and bounded bursts.
// Ports:
//   clk, reset_i          clock, asynchronous active-high reset.
//   req_sel_i/req_wr_i    per-requester request and write flag.
//   req_mask_i/addr/data  packed per-requester mask, address, write data.
//   req_ack_o             one-cycle completion pulse to the granted requester.
//   req_rdata_o           read data, valid while req_ack_o is high.
//   vram_sel_o .. vram_data_out_o   registered downstream request.
//   vram_data_in_i/vram_ack_i       downstream read data and completion.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ARB_IDLE | no transaction; arbitrate, a burst starts fresh here
// ARB_BUSY | vram_* held stable, waiting for vram_ack_i
// ARB_GAP  | one idle cycle after an ack; arbitrate, burst may continue
module vram_arbiter
  import graphite_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = VRAM_ADDR_W,
  parameter int DATA_WIDTH = VRAM_DATA_W,
  parameter int MASK_WIDTH = VRAM_MASK_W,
  parameter int BURST_MAX  = 8
) (
  input  logic                          clk,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0]            req_sel_i,
  input  logic [NUM_REQ-1:0]            req_wr_i,
  input  logic [NUM_REQ*MASK_WIDTH-1:0] req_mask_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ack_o,
  output logic [DATA_WIDTH-1:0]         req_rdata_o,
  output logic                          vram_sel_o,
  output logic                          vram_wr_o,
  output logic [MASK_WIDTH-1:0]         vram_mask_o,
  output logic [ADDR_WIDTH-1:0]         vram_addr_o,
  output logic [DATA_WIDTH-1:0]         vram_data_out_o,
  input  logic [DATA_WIDTH-1:0]         vram_data_in_i,
  input  logic                          vram_ack_i
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int BW = idx_width(BURST_MAX);
  localparam logic [IW-1:0] LAST_RESET = IW'(NUM_REQ - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

  arb_state_t state, state_nxt;

  // last_grant is also the owner of the transaction in flight during BUSY.
  logic [IW-1:0] last_grant;
  logic [IW-1:0] grant_nxt;
  logic [IW-1:0] rr_grant;
  logic [BW-1:0] burst_cnt, burst_nxt;
  logic          any_req;
  logic          take;
  logic          done;

  logic                  sel_wr;
  logic [MASK_WIDTH-1:0] sel_mask;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_picker #(
    .N(NUM_REQ)
  ) u_rr_picker (
    .req     (req_sel_i),
    .last    (last_grant),
    .grant   (rr_grant),
    .any_req (any_req)
  );

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state      <= ARB_IDLE;
      last_grant <= LAST_RESET;
      burst_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      if (take) begin
        last_grant <= grant_nxt;
      end
    end
  end

  // Arbitration out of IDLE always starts a new burst with a pure round-robin
  // pick: bursts only chain across back-to-back transactions (GAP). This is
  // what lets requester 0 win the first tie after reset. Once a burst is used
  // up and nobody else is asking, rr_grant comes back to last_grant and
  // burst_cnt stays saturated, so the first competing request switches over.
  always_comb begin
    state_nxt = state;
    grant_nxt = rr_grant;
    burst_nxt = burst_cnt;
    take      = 1'b0;
    done      = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (any_req) begin
          take      = 1'b1;
          burst_nxt = '0;
          state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (vram_ack_i) begin
          done      = 1'b1;
          state_nxt = ARB_GAP;
        end
      end
      ARB_GAP: begin
        if (any_req) begin
          take      = 1'b1;
          state_nxt = ARB_BUSY;
          if (req_sel_i[last_grant] && (burst_cnt < BURST_LAST)) begin
            grant_nxt = last_grant;
            burst_nxt = burst_cnt + 1'b1;
          end else if (rr_grant != last_grant) begin
            burst_nxt = '0;
          end
        end else begin
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    sel_wr   = 1'b0;
    sel_mask = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_nxt == IW'(i)) begin
        sel_wr   = req_wr_i[i];
        sel_mask = req_mask_i[i*MASK_WIDTH +: MASK_WIDTH];
        sel_addr = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Mask/addr/data are left as-is after the ack; only sel and wr are dropped.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      vram_sel_o      <= 1'b0;
      vram_wr_o       <= 1'b0;
      vram_mask_o     <= '0;
      vram_addr_o     <= '0;
      vram_data_out_o <= '0;
    end else if (take) begin
      vram_sel_o      <= 1'b1;
      vram_wr_o       <= sel_wr;
      vram_mask_o     <= sel_mask;
      vram_addr_o     <= sel_addr;
      vram_data_out_o <= sel_data;
    end else if (done) begin
      vram_sel_o <= 1'b0;
      vram_wr_o  <= 1'b0;
    end
  end

  always_comb begin
    req_ack_o = '0;
    if ((state == ARB_BUSY) && vram_ack_i) begin
      req_ack_o[last_grant] = 1'b1;
    end
  end

  assign req_rdata_o = vram_data_in_i;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: table-driven single transactions, hand sequences for
// contention / sole requester / async reset, then randomized traffic
// checked against a transaction-level reference model.
module tb_vram_arbiter;
  import graphite_pkg::*;

  localparam int N  = 2;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MW = 4;
  localparam int BM = 8;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [N-1:0]    req_sel_i;
  logic [N-1:0]    req_wr_i;
  logic [N*MW-1:0] req_mask_i;
  logic [N*AW-1:0] req_addr_i;
  logic [N*DW-1:0] req_data_i;
  logic [N-1:0]    req_ack_o;
  logic [DW-1:0]   req_rdata_o;
  logic            vram_sel_o;
  logic            vram_wr_o;
  logic [MW-1:0]   vram_mask_o;
  logic [AW-1:0]   vram_addr_o;
  logic [DW-1:0]   vram_data_out_o;
  logic [DW-1:0]   vram_data_in_i;
  logic            vram_ack_i;

  logic [AW-1:0] r_addr [N];
  logic [DW-1:0] r_data [N];
  logic [MW-1:0] r_mask [N];

  int vec_cnt = 0;
  int err_cnt = 0;
  int age     = 0;
  int lat     = 1;

  vram_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .BURST_MAX(BM)
  ) dut (
    .clk             (clk),
    .reset_i         (reset_i),
    .req_sel_i       (req_sel_i),
    .req_wr_i        (req_wr_i),
    .req_mask_i      (req_mask_i),
    .req_addr_i      (req_addr_i),
    .req_data_i      (req_data_i),
    .req_ack_o       (req_ack_o),
    .req_rdata_o     (req_rdata_o),
    .vram_sel_o      (vram_sel_o),
    .vram_wr_o       (vram_wr_o),
    .vram_mask_o     (vram_mask_o),
    .vram_addr_o     (vram_addr_o),
    .vram_data_out_o (vram_data_out_o),
    .vram_data_in_i  (vram_data_in_i),
    .vram_ack_i      (vram_ack_i)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_addr_i = '0;
    req_data_i = '0;
    req_mask_i = '0;
    for (int i = 0; i < N; i++) begin
      req_addr_i[i*AW +: AW] = r_addr[i];
      req_data_i[i*DW +: DW] = r_data[i];
      req_mask_i[i*MW +: MW] = r_mask[i];
    end
  end

  typedef struct {
    logic [N-1:0]  sel;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
    int            lat;
    logic [DW-1:0] din;
    int            exp_g;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Downstream responder: ack once sel has been high for l cycles.
  task automatic drive_ack(input int l);
    if (vram_sel_o) begin
      age++;
      vram_ack_i = (age > l);
    end else begin
      age = 0;
      vram_ack_i = 1'b0;
    end
  endtask

  function automatic int ack_index(input logic [N-1:0] a);
    int idx = -1;
    int ones = 0;
    for (int i = 0; i < N; i++) begin
      if (a[i]) begin
        idx = i;
        ones++;
      end
    end
    return (ones == 1) ? idx : -1;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] sel, input int last);
    for (int k = 1; k <= N; k++) begin
      if (sel[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset_i        = 1'b1;
    req_sel_i      = '0;
    req_wr_i       = '0;
    vram_ack_i     = 1'b0;
    vram_data_in_i = '0;
    age            = 0;
    for (int i = 0; i < N; i++) begin
      r_addr[i] = '0;
      r_data[i] = '0;
      r_mask[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
  endtask

  task automatic apply_vec(input vec_t e);
    for (int i = 0; i < N; i++) begin
      r_addr[i] = e.addr | (AW'(i) << 12);
      r_data[i] = e.data;
      r_mask[i] = e.mask;
    end
    req_wr_i   = {N{e.wr}};
    req_sel_i  = e.sel;
    vram_ack_i = 1'b0;
    settle();
    check("vec_pre_sel", 32'(vram_sel_o), 32'd0);
    for (int c = 0; c < e.lat; c++) begin
      step();
      settle();
      check("vec_sel", 32'(vram_sel_o), 32'd1);
      check("vec_addr", 32'(vram_addr_o), 32'(e.exp_addr));
      check("vec_wr", 32'(vram_wr_o), 32'(e.wr));
      check("vec_data", 32'(vram_data_out_o), 32'(e.data));
      check("vec_mask", 32'(vram_mask_o), 32'(e.mask));
      check("vec_no_ack", 32'(req_ack_o), 32'd0);
    end
    step();
    vram_ack_i     = 1'b1;
    vram_data_in_i = e.din;
    settle();
    check("vec_ack", 32'(req_ack_o), 32'(N'(1) << e.exp_g));
    if (!e.wr) check("vec_rdata", 32'(req_rdata_o), 32'(e.din));
    step();
    vram_ack_i = 1'b0;
    req_sel_i  = '0;
    settle();
    check("vec_gap_sel", 32'(vram_sel_o), 32'd0);
    check("vec_gap_wr", 32'(vram_wr_o), 32'd0);
    step();
    step();
  endtask

  task automatic new_req(input int i);
    req_sel_i[i] = 1'b1;
    req_wr_i[i]  = 1'($urandom_range(0, 1));
    r_addr[i]    = AW'($urandom);
    r_data[i]    = DW'($urandom);
    r_mask[i]    = MW'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants;
    int cyc;
    int last_ack_cyc;
    int m_phase;
    int m_last;
    int m_run;
    int g;
    logic          m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [MW-1:0] m_mask;
    logic [N-1:0]  exp_ack;
    logic [N-1:0]  acked;

    //            sel    wr    addr      data      mask  lat din       g  exp_addr
    tbl[0] = '{2'b01, 1'b1, 16'h0010, 16'hF123, 4'hF, 3, 16'h0000, 0, 16'h0010};
    tbl[1] = '{2'b10, 1'b0, 16'h0234, 16'h0000, 4'h0, 1, 16'hABCD, 1, 16'h1234};
    tbl[2] = '{2'b01, 1'b0, 16'h0ABC, 16'h0000, 4'h3, 2, 16'h1357, 0, 16'h0ABC};
    tbl[3] = '{2'b10, 1'b1, 16'h0FFF, 16'h0000, 4'h5, 1, 16'h0000, 1, 16'h1FFF};
    tbl[4] = '{2'b11, 1'b1, 16'h0200, 16'h8421, 4'hA, 2, 16'h0000, 0, 16'h0200};
    tbl[5] = '{2'b11, 1'b0, 16'h0300, 16'h0000, 4'h0, 1, 16'h5A5A, 1, 16'h1300};

    // Reset values, with a stray ack that must be ignored.
    reset_i    = 1'b1;
    req_sel_i  = '0;
    req_wr_i   = '0;
    vram_ack_i = 1'b1;
    vram_data_in_i = '0;
    for (int i = 0; i < N; i++) begin
      r_addr[i] = '1;
      r_data[i] = '1;
      r_mask[i] = '1;
    end
    #3;
    check("rst_sel", 32'(vram_sel_o), 32'd0);
    check("rst_wr", 32'(vram_wr_o), 32'd0);
    check("rst_mask", 32'(vram_mask_o), 32'd0);
    check("rst_addr", 32'(vram_addr_o), 32'd0);
    check("rst_data", 32'(vram_data_out_o), 32'd0);
    check("rst_ack", 32'(req_ack_o), 32'd0);
    do_reset();

    for (int v = 0; v < 6; v++) apply_vec(tbl[v]);

    // Contention: both always requesting, 1-cycle ack.
    do_reset();
    r_addr[0] = 16'h0100;
    r_addr[1] = 16'h1100;
    req_sel_i = 2'b11;
    grants = 0;
    cyc = 0;
    while (grants < 32 && cyc < 400) begin
      step();
      drive_ack(1);
      settle();
      cyc++;
      if (req_ack_o != '0) begin
        check("contention_grant", 32'(ack_index(req_ack_o)), 32'((grants / 8) % 2));
        grants++;
      end
    end
    check("contention_count", 32'(grants), 32'd32);

    // Sole requester: 20 back-to-back grants, one transaction every 3 cycles.
    do_reset();
    req_sel_i = 2'b01;
    grants = 0;
    cyc = 0;
    last_ack_cyc = 0;
    while (grants < 20 && cyc < 300) begin
      step();
      drive_ack(1);
      settle();
      cyc++;
      if (req_ack_o != '0) begin
        check("sole_grant", 32'(ack_index(req_ack_o)), 32'd0);
        if (grants > 0) check("sole_spacing", 32'(cyc - last_ack_cyc), 32'd3);
        last_ack_cyc = cyc;
        grants++;
      end
    end
    check("sole_count", 32'(grants), 32'd20);

    // Async reset while BUSY.
    do_reset();
    r_addr[0] = 16'h0ABC;
    r_data[0] = 16'h7777;
    req_wr_i  = 2'b01;
    req_sel_i = 2'b01;
    step();
    settle();
    check("arst_busy_sel", 32'(vram_sel_o), 32'd1);
    #2;
    reset_i = 1'b1;
    #1;
    check("arst_sel_drop", 32'(vram_sel_o), 32'd0);
    check("arst_addr_clr", 32'(vram_addr_o), 32'd0);
    vram_ack_i = 1'b1;
    #1;
    check("arst_ack_in_rst", 32'(req_ack_o), 32'd0);
    @(posedge clk);
    #1;
    reset_i   = 1'b0;
    req_sel_i = '0;
    settle();
    check("arst_late_ack", 32'(req_ack_o), 32'd0);
    check("arst_idle_sel", 32'(vram_sel_o), 32'd0);
    step();
    vram_ack_i = 1'b0;
    r_addr[1]  = 16'h1DEF;
    req_sel_i  = 2'b11;
    step();
    settle();
    check("arst_regrant_sel", 32'(vram_sel_o), 32'd1);
    check("arst_regrant_req0", 32'(vram_addr_o), 32'h0ABC);

    // Randomized traffic against the transaction-level model.
    do_reset();
    m_phase = 0;
    m_last  = N - 1;
    m_run   = 0;
    m_wr    = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    m_mask  = '0;
    acked   = '0;
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (acked[i]) begin
          if ($urandom_range(0, 1) == 1) new_req(i);
          else req_sel_i[i] = 1'b0;
        end else if (!req_sel_i[i] && $urandom_range(0, 3) == 0) begin
          new_req(i);
        end
      end
      if (vram_sel_o) begin
        age++;
        if (age == 1) lat = $urandom_range(1, 3);
        vram_ack_i = (age > lat);
      end else begin
        age = 0;
        vram_ack_i = ($urandom_range(0, 4) == 0);
      end
      vram_data_in_i = DW'($urandom);
      settle();

      exp_ack = (m_phase == 1 && vram_ack_i) ? (N'(1) << m_last) : '0;
      check("rand_ack", 32'(req_ack_o), 32'(exp_ack));
      if (exp_ack != '0 && !m_wr) check("rand_rdata", 32'(req_rdata_o), 32'(vram_data_in_i));
      check("rand_sel", 32'(vram_sel_o), 32'(m_phase == 1));
      if (m_phase == 1) begin
        check("rand_wr", 32'(vram_wr_o), 32'(m_wr));
        check("rand_addr", 32'(vram_addr_o), 32'(m_addr));
        check("rand_data", 32'(vram_data_out_o), 32'(m_data));
        check("rand_mask", 32'(vram_mask_o), 32'(m_mask));
      end
      acked = req_ack_o;

      g = -1;
      case (m_phase)
        0: if (req_sel_i != '0) begin
             g = rr_pick(req_sel_i, m_last);
             m_run = 1;
           end
        1: if (vram_ack_i) m_phase = 2;
        default: begin
          if (req_sel_i != '0) begin
            if (req_sel_i[m_last] && m_run < BM) g = m_last;
            else g = rr_pick(req_sel_i, m_last);
            m_run = (g == m_last) ? m_run + 1 : 1;
          end else begin
            m_phase = 0;
          end
        end
      endcase
      if (g >= 0) begin
        m_wr    = req_wr_i[g];
        m_addr  = r_addr[g];
        m_data  = r_data[g];
        m_mask  = r_mask[g];
        m_last  = g;
        m_phase = 1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
